pipe_reg_chain: RTL and testbench
=================================

# pipe_reg_chain

Parametrised multi-stage register pipeline with valid/ready handshake, generalising the single async-reset D flip-flop to WIDTH-bit data, DEPTH stages, bubble collapsing, back-pressure, synchronous flush and an occupancy count. Sits between any producer/consumer pair that needs retiming or elastic buffering of up to DEPTH words. All state is cleared by an asynchronous active-low reset.

## Interface
- WIDTH, 8, data bits per stage (≥1)
- DEPTH, 3, number of register stages (≥1)
- RST_VAL, '0, value loaded into every data register on reset and on flush
- clk  input  1  single clock, all state updates on posedge
- rst  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- flush  input  1  synchronous clear of all stages, active-high
- in_valid  input  1  producer has a word on in_data
- in_data  input  WIDTH  producer word
- in_ready  output  1  pipeline accepts in_data this cycle
- out_valid  output  1  last stage holds a valid word
- out_data  output  WIDTH  last-stage word
- out_ready  input  1  consumer takes out_data this cycle
- count  output  $clog2(DEPTH+1)  number of valid stages, registered

## Operation
- Each stage i (0 = input side, DEPTH-1 = output side) holds vld[i] and dat[i].
- Stage readiness: rdy[DEPTH-1] = !vld[DEPTH-1] | out_ready; rdy[i] = !vld[i] | rdy[i+1]. in_ready = rdy[0] & !flush.
- Stage i loads from stage i-1 (or from in_data for i=0) when rdy[i]; vld[i] <= vld[i-1] (or in_valid & in_ready). dat[i] updates only when the incoming valid is 1; otherwise dat holds (no gratuitous toggling).
- Stage i holds when !rdy[i]. Bubbles (vld=0) collapse: a stalled head never blocks a word behind an empty stage.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready. out_valid = vld[DEPTH-1], out_data = dat[DEPTH-1] (direct register outputs).
- flush: next edge all vld <= 0, all dat <= RST_VAL, count <= 0; input in that cycle is dropped (in_ready = 0); output handshake in that cycle is still reported but the word is discarded by flush regardless.
- count: count <= count + in_xfer − out_xfer; never exceeds DEPTH, never underflows. Under flush, 0.
- Data ordering strictly FIFO; no word duplicated or lost except by flush/reset.

## Timing
- Reset (rst=0, asynchronous): vld all 0, dat all RST_VAL, count 0; out_valid=0, out_data=RST_VAL, in_ready=1 immediately (combinational from vld). Release is synchronous in effect: first capture at first posedge with rst=1.
- Latency: word accepted at edge n appears on out_valid/out_data after edge n+DEPTH−1 when unobstructed (DEPTH cycles in-to-out-register, DEPTH=1 → visible one cycle after accept).
- Throughput: one word/cycle with out_ready held high.
- Full (all vld=1) and out_ready=0: in_ready=0, all stages hold. Full with out_ready=1: in_ready=1, simultaneous in and out, count unchanged.
- Empty: out_valid=0; in_ready=1.
- in_ready depends combinationally on out_ready (ripple through DEPTH stages); documented, not registered.
- rst asserted mid-stream: all in-flight words lost at once, independent of clk.
- flush and rst both active: rst dominates.

## Structure
- Package pipe_pkg: function cnt_w(depth) = $clog2(depth+1) for count width; no typedefs beyond that.
- Sub-module pipe_stage (one vld/dat register pair with load/hold/flush, async reset to 0/RST_VAL), instantiated DEPTH times by a generate loop; top holds readiness chain and count.

## Test plan
- Reset: drive rst=0 mid-cycle with vld stages full → immediately out_valid=0, count=0, out_data=RST_VAL, in_ready=1.
- Streaming (DEPTH=3, WIDTH=8): out_ready=1, send 0x11,0x22,0x33,0x44 on consecutive cycles → out_data 0x11..0x44 on consecutive cycles, first after 3 edges, count steady at 3.
- Back-pressure: out_ready=0, send 5 words → 3 accepted, in_ready=0 after 3rd, count=3; raise out_ready → words exit in order, 4th/5th accepted as slots free.
- Bubble collapse: send 0xA5, idle 2 cycles, send 0x5A with out_ready=0 → both packed in stages 2 and 1, count=2, in_ready=1.
- Full simultaneous: full pipe, in_valid=1, out_ready=1 for 4 cycles → 4 in, 4 out, count stays 3, order preserved.
- Flush: pipe holding 2 words, flush=1 with in_valid=1 → in_ready=0 that cycle; next cycle count=0, out_valid=0, out_data=RST_VAL; dropped input never appears.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared helpers for the register pipeline: sizing of the occupancy counter.
package pipe_pkg;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/pipe_reg_chain_stage.sv
// One pipeline slot: a valid bit plus data word with load/hold/flush.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_load,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_dat
);
  logic             r_vld;
  logic [WIDTH-1:0] r_dat;

  // Data only moves with a valid word so idle slots do not toggle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= 1'b0;
      r_dat <= RST_VAL;
    end else if (i_flush) begin
      r_vld <= 1'b0;
      r_dat <= RST_VAL;
    end else if (i_load) begin
      r_vld <= i_vld;
      if (i_vld) r_dat <= i_dat;
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;
endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage register pipeline with bubble collapsing, flush and
// occupancy count. in_ready ripples combinationally from out_ready.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [cnt_w(DEPTH)-1:0]    count
);
  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH-1:0]            w_vld, w_rdy, w_vin;
  logic [DEPTH-1:0][WIDTH-1:0] w_dat, w_din;
  logic                        w_in_xfer, w_out_xfer;
  logic [CW-1:0]               r_count;

  // A stage can take a word if it is empty or its successor can take its word.
  always_comb begin
    w_rdy            = '0;
    w_rdy[DEPTH-1]   = !w_vld[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--)
      w_rdy[i] = !w_vld[i] | w_rdy[i+1];
  end

  assign in_ready   = w_rdy[0] & !flush;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = w_vld[DEPTH-1] & out_ready;

  always_comb begin
    w_vin    = '0;
    w_din    = '0;
    w_vin[0] = w_in_xfer;
    w_din[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      w_vin[i] = w_vld[i-1];
      w_din[i] = w_dat[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipe_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_flush (flush),
      .i_load  (w_rdy[g]),
      .i_vld   (w_vin[g]),
      .i_dat   (w_din[g]),
      .o_vld   (w_vld[g]),
      .o_dat   (w_dat[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_count <= '0;
    else if (flush) r_count <= '0;
    else            r_count <= r_count + CW'(w_in_xfer) - CW'(w_out_xfer);
  end

  assign out_valid = w_vld[DEPTH-1];
  assign out_data  = w_dat[DEPTH-1];
  assign count     = r_count;
endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed table-driven bench for pipe_reg_chain (WIDTH=8, DEPTH=3).
module tb_pipe_reg_chain;
  localparam int         WIDTH = 8;
  localparam int         DEPTH = 3;
  localparam logic [7:0] RV    = 8'hE7;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [1:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       fl;
    logic       e_irdy;  // in_ready before the edge
    logic       e_ov;    // after the edge
    logic [7:0] e_od;
    logic [1:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RV)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t V(logic iv, logic [7:0] id, logic ordy, logic fl,
                             logic eir, logic eov, logic [7:0] eod, logic [1:0] ecnt);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
    v.e_irdy = eir; v.e_ov = eov; v.e_od = eod; v.e_cnt = ecnt;
    return v;
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    @(negedge clk);
    in_valid  = v.iv;
    in_data   = v.id;
    out_ready = v.ordy;
    flush     = v.fl;
    #1;
    chk($sformatf("%s in_ready", tag), 32'(in_ready), 32'(v.e_irdy));
    @(posedge clk);
    #1;
    chk($sformatf("%s out_valid", tag), 32'(out_valid), 32'(v.e_ov));
    chk($sformatf("%s out_data", tag), 32'(out_data), 32'(v.e_od));
    chk($sformatf("%s count", tag), 32'(count), 32'(v.e_cnt));
  endtask

  initial begin
    // streaming, out_ready held high
    vecs.push_back(V(1, 8'h11, 1, 0, 1, 0, RV,    1));
    vecs.push_back(V(1, 8'h22, 1, 0, 1, 0, RV,    2));
    vecs.push_back(V(1, 8'h33, 1, 0, 1, 1, 8'h11, 3));
    vecs.push_back(V(1, 8'h44, 1, 0, 1, 1, 8'h22, 3));
    vecs.push_back(V(0, 8'h00, 1, 0, 1, 1, 8'h33, 2));
    vecs.push_back(V(0, 8'h00, 1, 0, 1, 1, 8'h44, 1));
    vecs.push_back(V(0, 8'h00, 1, 0, 1, 0, 8'h44, 0));
    // back-pressure
    vecs.push_back(V(1, 8'h01, 0, 0, 1, 0, 8'h44, 1));
    vecs.push_back(V(1, 8'h02, 0, 0, 1, 0, 8'h44, 2));
    vecs.push_back(V(1, 8'h03, 0, 0, 1, 1, 8'h01, 3));
    vecs.push_back(V(1, 8'h04, 0, 0, 0, 1, 8'h01, 3));
    vecs.push_back(V(1, 8'h04, 1, 0, 1, 1, 8'h02, 3));
    vecs.push_back(V(1, 8'h05, 1, 0, 1, 1, 8'h03, 3));
    vecs.push_back(V(0, 8'h00, 1, 0, 1, 1, 8'h04, 2));
    vecs.push_back(V(0, 8'h00, 1, 0, 1, 1, 8'h05, 1));
    vecs.push_back(V(0, 8'h00, 1, 0, 1, 0, 8'h05, 0));
    // bubble collapse behind a stalled head
    vecs.push_back(V(1, 8'hA5, 0, 0, 1, 0, 8'h05, 1));
    vecs.push_back(V(0, 8'h00, 0, 0, 1, 0, 8'h05, 1));
    vecs.push_back(V(0, 8'h00, 0, 0, 1, 1, 8'hA5, 1));
    vecs.push_back(V(1, 8'h5A, 0, 0, 1, 1, 8'hA5, 2));
    vecs.push_back(V(0, 8'h00, 0, 0, 1, 1, 8'hA5, 2));
    vecs.push_back(V(1, 8'hB1, 0, 0, 1, 1, 8'hA5, 3));
    vecs.push_back(V(1, 8'hB2, 0, 0, 0, 1, 8'hA5, 3));
    // full with simultaneous in/out
    vecs.push_back(V(1, 8'hB2, 1, 0, 1, 1, 8'h5A, 3));
    vecs.push_back(V(1, 8'hB3, 1, 0, 1, 1, 8'hB1, 3));
    vecs.push_back(V(1, 8'hB4, 1, 0, 1, 1, 8'hB2, 3));
    vecs.push_back(V(1, 8'hB5, 1, 0, 1, 1, 8'hB3, 3));
    // flush with two words held; input C7 must never appear
    vecs.push_back(V(0, 8'h00, 1, 0, 1, 1, 8'hB4, 2));
    vecs.push_back(V(1, 8'hC7, 1, 1, 0, 0, RV,    0));
    vecs.push_back(V(0, 8'h00, 1, 0, 1, 0, RV,    0));
    vecs.push_back(V(1, 8'hD1, 1, 0, 1, 0, RV,    1));
    vecs.push_back(V(0, 8'h00, 1, 0, 1, 0, RV,    1));
    vecs.push_back(V(0, 8'h00, 1, 0, 1, 1, 8'hD1, 1));
    vecs.push_back(V(0, 8'h00, 1, 0, 1, 0, 8'hD1, 0));

    // reset state while rst is held low
    #12;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'(RV));
    chk("reset count", 32'(count), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // fill the pipe, then pull rst mid-cycle: outputs clear without an edge
    run_vec("fill0", V(1, 8'h61, 0, 0, 1, 0, 8'hD1, 1));
    run_vec("fill1", V(1, 8'h62, 0, 0, 1, 0, 8'hD1, 2));
    run_vec("fill2", V(1, 8'h63, 0, 0, 1, 1, 8'h61, 3));
    @(posedge clk);
    #3;
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst count", 32'(count), 32'd0);
    chk("async rst out_data", 32'(out_data), 32'(RV));
    chk("async rst in_ready", 32'(in_ready), 32'd1);

    // reset dominates flush; first capture after release
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("rst+flush count", 32'(count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_vec("post-rst", V(1, 8'h77, 0, 0, 1, 0, RV, 1));
    run_vec("post-rst2", V(0, 8'h00, 0, 0, 1, 0, RV, 1));
    run_vec("post-rst3", V(0, 8'h00, 0, 0, 1, 1, 8'h77, 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
